uart_rx_arbiter: RTL and testbench
==================================

UART_RX_ARBITER -- requirements
Module: uart_rx_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 64: packet width without start/stop bits.
REQ-002 SHALL have parameter NUM_PORTS, default 4: number of RX UART channels.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 47: comms wait limit, used only with RX_TIMEOUT_EN.
REQ-004 SHALL use one clock and an asynchronous, active-high reset. Ports: clk input 1 (master clock); reset input 1 (async active-high).
REQ-005 SHALL have port rx_data_uart, input, NUM_PORTS x WIDTH packed: per-UART received packet.
REQ-006 SHALL have port rx_empty_uart, input, NUM_PORTS: high when the UART holds no RX data.
REQ-007 SHALL have port enable_posi, input, NUM_PORTS: high to accept that channel.
REQ-008 SHALL have port comms_busy, input, 1: downstream comms processing the current event.
REQ-009 SHALL have port uld_rx_data_uart, output, NUM_PORTS: one-cycle unload pulse per UART.
REQ-010 SHALL have port rx_data, output, WIDTH: event to FIFO.
REQ-011 SHALL have port rx_data_flag, output, 1: one-cycle pulse, rx_data valid.
REQ-012 SHALL have port grant, output, NUM_PORTS: one-hot source of current rx_data.
REQ-013 SHALL have port dropped, output, NUM_PORTS: sticky, data discarded from a disabled channel.
REQ-014 SHALL have port timeout_flag, output, 1: one-cycle pulse on comms timeout.

Function
REQ-015 SHALL hold one packet per channel in a register with a hold_valid bit.
REQ-016 SHALL capture when !rx_empty_uart[i] & enable_posi[i] & !hold_valid[i] & !uld_rx_data_uart[i]: at the clock edge, load the hold register, set hold_valid, and pulse uld_rx_data_uart[i] high for the next cycle.
REQ-017 SHALL, when hold_valid[i]=1, leave the UART untouched; the data stays in the UART as back-pressure, with no loss.
REQ-018 SHALL, when !rx_empty_uart[i] & !enable_posi[i], pulse uld_rx_data_uart[i], discard the data and set dropped[i].
REQ-019 SHALL implement FSM states IDLE, GRANT, ISSUE, WAIT_COMMS.
REQ-020 SHALL transition IDLE->GRANT when any hold_valid is set; otherwise it stays in IDLE.
REQ-021 SHALL, in GRANT, select by round-robin starting at last_grant+1 with wrap NUM_PORTS-1->0; register rx_data and grant, clear the selected hold_valid, update last_grant, then go to ISSUE.
REQ-022 SHALL, in ISSUE, assert rx_data_flag for exactly one cycle and then go to WAIT_COMMS.
REQ-023 SHALL stay in WAIT_COMMS for at least one cycle and while comms_busy is high; on exit it goes to GRANT if any hold_valid is set, else to IDLE.
REQ-024 SHALL give a latency of 3 cycles from a capture-eligible cycle n on an idle block to rx_data_flag high in cycle n+3.
REQ-025 SHALL keep rx_data and grant stable until the next GRANT.
REQ-026 SHALL, if enable_posi[i] falls while hold_valid[i]=1, still forward the held packet.
REQ-027 SHALL allow a capture and a grant on the same channel in the same cycle, where the grant clears hold_valid and the capture is blocked until the next cycle.

Reset
REQ-028 SHALL, on reset, clear to zero: rx_data, rx_data_flag, grant, uld_rx_data_uart, dropped, timeout_flag, all hold_valid bits and the timeout counter; set the state to IDLE and last_grant to NUM_PORTS-1.
REQ-029 SHALL discard held packets on a reset mid-operation, with no unload pulses during reset.

Configuration
REQ-030 SHALL, with RX_TIMEOUT_EN defined, count cycles in WAIT_COMMS; when the count reaches TIMEOUT_CYCLES-1 with comms_busy still high, it forces exit and pulses timeout_flag.
REQ-031 SHALL, without RX_TIMEOUT_EN, remove the counter, wait indefinitely and tie timeout_flag to 0.

Structure
REQ-032 SHALL place the FSM state enum and the NUM_PORTS default in shared package hydra_pkg.
REQ-033 SHALL implement round-robin selection and the last_grant register in sub-module rr_arbiter, with ports req, advance, gnt.

Verification
REQ-034 SHALL cover: rx_empty_uart=4'b1110, rx_data_uart[0]=64'hA5, comms_busy=0 -> uld_rx_data_uart=4'b0001 for 1 cycle, rx_data=64'hA5, rx_data_flag 3 cycles later, grant=4'b0001.
REQ-035 SHALL cover: all four channels capture in the same cycle -> rx_data_flag pulses in order ch0,1,2,3, each with its data.
REQ-036 SHALL cover: after a ch2 grant, ch0 and ch3 pending -> next grant ch3, then ch0.
REQ-037 SHALL cover: enable_posi=4'b1101, ch1 not empty -> unload pulse on ch1, dropped=4'b0010, no rx_data_flag.
REQ-038 SHALL cover: with RX_TIMEOUT_EN, comms_busy held high -> timeout_flag after 47 WAIT_COMMS cycles, then the next pending packet is issued; without RX_TIMEOUT_EN the block waits until comms_busy falls.
REQ-039 SHALL cover: reset asserted while in WAIT_COMMS with two packets held -> all outputs 0, state IDLE, no rx_data_flag after release until new data arrives.

Source files
------------

// File: rtl/hydra_pkg.sv
// hydra_pkg: shared defaults, FSM state type and a sizing helper for the
// uart_rx_arbiter slice (top, rr_arbiter sub-module).
package hydra_pkg;

  localparam int DEFAULT_NUM_PORTS      = 4;
  localparam int DEFAULT_WIDTH          = 64;
  localparam int DEFAULT_TIMEOUT_CYCLES = 47;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    GRANT      = 2'd1,
    ISSUE      = 2'd2,
    WAIT_COMMS = 2'd3
  } arb_state_e;

  // Bits needed to hold values 0..n-1, never less than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin picker over a request vector. The search starts one
// past the last granted index and wraps NUM_PORTS-1 -> 0. last_grant only moves
// when 'advance' is asserted and a request is actually present.
module rr_arbiter
  import hydra_pkg::*;
#(
  parameter int NUM_PORTS = DEFAULT_NUM_PORTS
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_PORTS-1:0] req,
  input  logic                 advance,
  output logic [NUM_PORTS-1:0] gnt
);

  localparam int IdxW = idx_width(NUM_PORTS);

  logic [IdxW-1:0] last_q;
  logic [IdxW-1:0] last_d;
  logic [IdxW-1:0] pick;
  logic [IdxW-1:0] cand;
  logic            found;
  int              idx;

  // Scan the requests in rotating priority order and keep the first hit.
  always_comb begin
    gnt   = '0;
    pick  = last_q;
    found = 1'b0;
    idx   = 0;
    cand  = '0;
    for (int off = 1; off <= NUM_PORTS; off++) begin
      idx = int'(last_q) + off;
      if (idx >= NUM_PORTS) begin
        idx = idx - NUM_PORTS;
      end
      cand = IdxW'(idx);
      if (!found && req[cand]) begin
        found     = 1'b1;
        gnt[cand] = 1'b1;
        pick      = cand;
      end
    end
  end

  // Remember the winner so the next search begins just after it.
  always_comb begin
    last_d = last_q;
    if (advance && found) begin
      last_d = pick;
    end
  end

  // last_grant starts at the top index so channel 0 has first priority.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_q <= IdxW'(NUM_PORTS - 1);
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/uart_rx_arbiter.sv
// uart_rx_arbiter: pulls packets from NUM_PORTS RX UARTs into per-channel hold
// registers and forwards them one at a time, round-robin, to a downstream FIFO.
// Packets from disabled channels are unloaded and discarded (sticky 'dropped').
// Optional feature: define RX_TIMEOUT_EN to bound the wait on comms_busy to
// TIMEOUT_CYCLES cycles; without it the block waits indefinitely and
// timeout_flag is constant zero.
module uart_rx_arbiter
  import hydra_pkg::*;
#(
  parameter int WIDTH          = DEFAULT_WIDTH,
  parameter int NUM_PORTS      = DEFAULT_NUM_PORTS,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_PORTS-1:0][WIDTH-1:0]  rx_data_uart,
  input  logic [NUM_PORTS-1:0]             rx_empty_uart,
  input  logic [NUM_PORTS-1:0]             enable_posi,
  input  logic                             comms_busy,
  output logic [NUM_PORTS-1:0]             uld_rx_data_uart,
  output logic [WIDTH-1:0]                 rx_data,
  output logic                             rx_data_flag,
  output logic [NUM_PORTS-1:0]             grant,
  output logic [NUM_PORTS-1:0]             dropped,
  output logic                             timeout_flag
);

  arb_state_e state_q;
  arb_state_e state_d;

  logic [NUM_PORTS-1:0][WIDTH-1:0] hold_q;
  logic [NUM_PORTS-1:0][WIDTH-1:0] hold_d;
  logic [NUM_PORTS-1:0]            hold_valid_q;
  logic [NUM_PORTS-1:0]            hold_valid_d;
  logic [NUM_PORTS-1:0]            uld_q;
  logic [NUM_PORTS-1:0]            uld_d;
  logic [NUM_PORTS-1:0]            dropped_q;
  logic [NUM_PORTS-1:0]            dropped_d;
  logic [WIDTH-1:0]                rx_data_q;
  logic [NUM_PORTS-1:0]            grant_q;

  logic [NUM_PORTS-1:0] arb_gnt;
  logic [WIDTH-1:0]     sel_data;
  logic                 grant_now;
  logic                 timeout_hit;

  assign grant_now = (state_q == GRANT);

  rr_arbiter #(
    .NUM_PORTS(NUM_PORTS)
  ) u_rr (
    .clk    (clk),
    .reset  (reset),
    .req    (hold_valid_q),
    .advance(grant_now),
    .gnt    (arb_gnt)
  );

`ifdef RX_TIMEOUT_EN
  localparam int CntW = idx_width(TIMEOUT_CYCLES);

  logic [CntW-1:0] cnt_q;
  logic [CntW-1:0] cnt_d;

  // Count cycles spent in WAIT_COMMS; the count restarts on every entry.
  always_comb begin
    cnt_d = '0;
    if (state_q == WAIT_COMMS) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  // Timeout counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign timeout_hit = (state_q == WAIT_COMMS) && comms_busy &&
                       (cnt_q == CntW'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  // Capture, drop and release of the per-channel hold registers. A channel that
  // is already holding a packet leaves the UART alone so it back-pressures; the
  // unload pulse of the previous cycle blocks a second look at stale UART data.
  always_comb begin
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q;
    uld_d        = '0;
    dropped_d    = dropped_q;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (!rx_empty_uart[i] && !uld_q[i]) begin
        if (enable_posi[i]) begin
          if (!hold_valid_q[i]) begin
            hold_d[i]       = rx_data_uart[i];
            hold_valid_d[i] = 1'b1;
            uld_d[i]        = 1'b1;
          end
        end else begin
          uld_d[i]     = 1'b1;
          dropped_d[i] = 1'b1;
        end
      end
    end
    if (grant_now) begin
      hold_valid_d = hold_valid_d & ~arb_gnt;
    end
  end

  // One-hot mux of the held packet chosen by the arbiter.
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (arb_gnt[i]) begin
        sel_data = sel_data | hold_q[i];
      end
    end
  end

  // Hold registers, unload pulses and the sticky drop flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_q       <= '0;
      hold_valid_q <= '0;
      uld_q        <= '0;
      dropped_q    <= '0;
    end else begin
      hold_q       <= hold_d;
      hold_valid_q <= hold_valid_d;
      uld_q        <= uld_d;
      dropped_q    <= dropped_d;
    end
  end

  // Output packet and source register, only reloaded in GRANT.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_data_q <= '0;
      grant_q   <= '0;
    end else if (grant_now) begin
      rx_data_q <= sel_data;
      grant_q   <= arb_gnt;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: grant, issue for one cycle, then wait on downstream comms.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (|hold_valid_q) begin
          state_d = GRANT;
        end
      end
      GRANT: begin
        state_d = ISSUE;
      end
      ISSUE: begin
        state_d = WAIT_COMMS;
      end
      WAIT_COMMS: begin
        if (!comms_busy || timeout_hit) begin
          state_d = (|hold_valid_q) ? GRANT : IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // FSM outputs: one-cycle valid strobe and timeout strobe.
  always_comb begin
    rx_data_flag = (state_q == ISSUE);
    timeout_flag = timeout_hit;
  end

  assign uld_rx_data_uart = uld_q;
  assign rx_data          = rx_data_q;
  assign grant            = grant_q;
  assign dropped          = dropped_q;

endmodule

// File: tb/tb_uart_rx_arbiter.sv
// tb_uart_rx_arbiter: directed, self-checking bench for uart_rx_arbiter with
// default parameters. Honours RX_TIMEOUT_EN when the design is built with it.
module tb_uart_rx_arbiter;
  import hydra_pkg::*;

  localparam int W = 64;
  localparam int N = 4;

  logic                   clk = 1'b0;
  logic                   reset;
  logic [N-1:0][W-1:0]    rx_data_uart;
  logic [N-1:0]           rx_empty_uart;
  logic [N-1:0]           enable_posi;
  logic                   comms_busy;
  logic [N-1:0]           uld_rx_data_uart;
  logic [W-1:0]           rx_data;
  logic                   rx_data_flag;
  logic [N-1:0]           grant;
  logic [N-1:0]           dropped;
  logic                   timeout_flag;

  int checks   = 0;
  int failures = 0;
  int cycleCount = 0;

  int           flagCycle[$];
  logic [N-1:0] flagGrant[$];
  logic [W-1:0] flagData[$];
  int           timeoutCycle[$];
  int           uldCount[N];
  int           uldFirst[N];

  uart_rx_arbiter dut (
    .clk             (clk),
    .reset           (reset),
    .rx_data_uart    (rx_data_uart),
    .rx_empty_uart   (rx_empty_uart),
    .enable_posi     (enable_posi),
    .comms_busy      (comms_busy),
    .uld_rx_data_uart(uld_rx_data_uart),
    .rx_data         (rx_data),
    .rx_data_flag    (rx_data_flag),
    .grant           (grant),
    .dropped         (dropped),
    .timeout_flag    (timeout_flag)
  );

  always #5 clk = ~clk;

  task automatic clearLog();
    flagCycle.delete();
    flagGrant.delete();
    flagData.delete();
    timeoutCycle.delete();
    for (int i = 0; i < N; i++) begin
      uldCount[i] = 0;
      uldFirst[i] = -1;
    end
  endtask

  task automatic applyStimulus(input logic [N-1:0] empty, input logic [N-1:0] en,
                               input logic busy);
    rx_empty_uart = empty;
    enable_posi   = en;
    comms_busy    = busy;
  endtask

  task automatic resetDut();
    reset        = 1'b1;
    rx_data_uart = '0;
    applyStimulus('1, '1, 1'b0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    cycleCount = 0;
    clearLog();
  endtask

  // Advance n cycles, logging strobes; an unload pulse empties that UART.
  task automatic runCycles(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      cycleCount++;
      if (rx_data_flag) begin
        flagCycle.push_back(cycleCount);
        flagGrant.push_back(grant);
        flagData.push_back(rx_data);
      end
      if (timeout_flag) timeoutCycle.push_back(cycleCount);
      for (int i = 0; i < N; i++) begin
        if (uld_rx_data_uart[i]) begin
          if (uldCount[i] == 0) uldFirst[i] = cycleCount;
          uldCount[i]++;
          rx_empty_uart[i] = 1'b1;
        end
      end
    end
  endtask

  task automatic test_reset();
    resetDut();
    checks++; if (rx_data !== '0) begin failures++; $display("[TB] FAIL reset_rx_data: got %0h expected 0", rx_data); end
    checks++; if (rx_data_flag !== 1'b0) begin failures++; $display("[TB] FAIL reset_flag: got %0b expected 0", rx_data_flag); end
    checks++; if (grant !== '0) begin failures++; $display("[TB] FAIL reset_grant: got %b expected 0000", grant); end
    checks++; if (uld_rx_data_uart !== '0) begin failures++; $display("[TB] FAIL reset_uld: got %b expected 0000", uld_rx_data_uart); end
    checks++; if (dropped !== '0) begin failures++; $display("[TB] FAIL reset_dropped: got %b expected 0000", dropped); end
    checks++; if (timeout_flag !== 1'b0) begin failures++; $display("[TB] FAIL reset_timeout: got %0b expected 0", timeout_flag); end
    checks++; if (dut.state_q !== IDLE) begin failures++; $display("[TB] FAIL reset_state: got %0d expected IDLE", dut.state_q); end
    checks++; if (dut.u_rr.last_q !== 2'd3) begin failures++; $display("[TB] FAIL reset_last_grant: got %0d expected 3", dut.u_rr.last_q); end
  endtask

  task automatic test_single();
    resetDut();
    rx_data_uart[0] = 64'hA5;
    applyStimulus(4'b1110, 4'b1111, 1'b0);
    runCycles(8);
    checks++; if (uldCount[0] !== 1) begin failures++; $display("[TB] FAIL single_uld_count: got %0d expected 1", uldCount[0]); end
    checks++; if (uldFirst[0] !== 1) begin failures++; $display("[TB] FAIL single_uld_cycle: got %0d expected 1", uldFirst[0]); end
    checks++; if (flagCycle.size() !== 1) begin
      failures++; $display("[TB] FAIL single_flag_count: got %0d expected 1", flagCycle.size());
    end else begin
      checks++; if (flagCycle[0] !== 3) begin failures++; $display("[TB] FAIL single_latency: got %0d expected 3", flagCycle[0]); end
      checks++; if (flagData[0] !== 64'hA5) begin failures++; $display("[TB] FAIL single_data: got %0h expected a5", flagData[0]); end
      checks++; if (flagGrant[0] !== 4'b0001) begin failures++; $display("[TB] FAIL single_grant: got %b expected 0001", flagGrant[0]); end
    end
    checks++; if (rx_data !== 64'hA5 || grant !== 4'b0001) begin failures++; $display("[TB] FAIL single_stable: got %0h/%b expected a5/0001", rx_data, grant); end
  endtask

  task automatic test_all_ports();
    logic [W-1:0] d [N];
    resetDut();
    for (int i = 0; i < N; i++) begin
      d[i] = 64'h1111_0000_0000_0000 * (i + 1) + 64'(i * 7 + 3);
      rx_data_uart[i] = d[i];
    end
    applyStimulus(4'b0000, 4'b1111, 1'b0);
    runCycles(20);
    checks++; if (flagCycle.size() !== N) begin failures++; $display("[TB] FAIL all_flag_count: got %0d expected 4", flagCycle.size()); end
    for (int k = 0; k < N; k++) begin
      if (k < flagCycle.size()) begin
        checks++; if (flagGrant[k] !== 4'(1 << k) || flagData[k] !== d[k] || flagCycle[k] !== 3 + 3 * k) begin
          failures++; $display("[TB] FAIL all_order_%0d: got grant %b data %0h cycle %0d expected %b %0h %0d",
                               k, flagGrant[k], flagData[k], flagCycle[k], 4'(1 << k), d[k], 3 + 3 * k);
        end
      end
    end
  endtask

  task automatic test_round_robin();
    logic [N-1:0] expG [3];
    logic [W-1:0] expD [3];
    expG[0] = 4'b0100; expG[1] = 4'b1000; expG[2] = 4'b0001;
    expD[0] = 64'hC2;  expD[1] = 64'hC3;  expD[2] = 64'hC0;
    resetDut();
    rx_data_uart[2] = 64'hC2;
    applyStimulus(4'b1011, 4'b1111, 1'b1);
    runCycles(6);
    rx_data_uart[0] = 64'hC0;
    rx_data_uart[3] = 64'hC3;
    rx_empty_uart = 4'b0110;
    runCycles(4);
    comms_busy = 1'b0;
    runCycles(12);
    checks++; if (flagCycle.size() !== 3) begin failures++; $display("[TB] FAIL rr_flag_count: got %0d expected 3", flagCycle.size()); end
    for (int k = 0; k < 3; k++) begin
      if (k < flagCycle.size()) begin
        checks++; if (flagGrant[k] !== expG[k] || flagData[k] !== expD[k]) begin
          failures++; $display("[TB] FAIL rr_order_%0d: got %b/%0h expected %b/%0h", k, flagGrant[k], flagData[k], expG[k], expD[k]);
        end
      end
    end
  endtask

  task automatic test_drop();
    resetDut();
    rx_data_uart[1] = 64'hDEAD;
    applyStimulus(4'b1101, 4'b1101, 1'b0);
    runCycles(8);
    checks++; if (uldCount[1] !== 1 || uldFirst[1] !== 1) begin failures++; $display("[TB] FAIL drop_uld: got count %0d cycle %0d expected 1 1", uldCount[1], uldFirst[1]); end
    checks++; if (uldCount[0] + uldCount[2] + uldCount[3] !== 0) begin failures++; $display("[TB] FAIL drop_other_uld: got %0d expected 0", uldCount[0] + uldCount[2] + uldCount[3]); end
    checks++; if (dropped !== 4'b0010) begin failures++; $display("[TB] FAIL drop_sticky: got %b expected 0010", dropped); end
    checks++; if (flagCycle.size() !== 0) begin failures++; $display("[TB] FAIL drop_no_flag: got %0d expected 0", flagCycle.size()); end
  endtask

  task automatic test_same_cycle();
    resetDut();
    rx_data_uart[0] = 64'hAAAA;
    applyStimulus(4'b1110, 4'b1111, 1'b0);
    @(posedge clk); #1;
    checks++; if (uld_rx_data_uart !== 4'b0001) begin failures++; $display("[TB] FAIL same_uld1: got %b expected 0001", uld_rx_data_uart); end
    rx_data_uart[0] = 64'hBBBB;
    @(posedge clk); #1;
    checks++; if (uld_rx_data_uart !== 4'b0000) begin failures++; $display("[TB] FAIL same_uld2: got %b expected 0000", uld_rx_data_uart); end
    @(posedge clk); #1;
    checks++; if (rx_data_flag !== 1'b1 || rx_data !== 64'hAAAA || uld_rx_data_uart !== 4'b0000) begin
      failures++; $display("[TB] FAIL same_issue_a: got flag %0b data %0h uld %b expected 1 aaaa 0000", rx_data_flag, rx_data, uld_rx_data_uart);
    end
    @(posedge clk); #1;
    checks++; if (uld_rx_data_uart !== 4'b0001) begin failures++; $display("[TB] FAIL same_uld_b: got %b expected 0001", uld_rx_data_uart); end
    rx_empty_uart = 4'b1111;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++; if (rx_data_flag !== 1'b1 || rx_data !== 64'hBBBB || grant !== 4'b0001) begin
      failures++; $display("[TB] FAIL same_issue_b: got flag %0b data %0h grant %b expected 1 bbbb 0001", rx_data_flag, rx_data, grant);
    end
  endtask

  task automatic test_enable_fall();
    resetDut();
    rx_data_uart[1] = 64'hC1C1;
    applyStimulus(4'b1101, 4'b1111, 1'b0);
    runCycles(1);
    checks++; if (uldCount[1] !== 1) begin failures++; $display("[TB] FAIL enfall_uld: got %0d expected 1", uldCount[1]); end
    enable_posi = 4'b1101;
    runCycles(6);
    checks++; if (flagCycle.size() !== 1) begin
      failures++; $display("[TB] FAIL enfall_flag_count: got %0d expected 1", flagCycle.size());
    end else begin
      checks++; if (flagData[0] !== 64'hC1C1 || flagGrant[0] !== 4'b0010) begin failures++; $display("[TB] FAIL enfall_data: got %0h/%b expected c1c1/0010", flagData[0], flagGrant[0]); end
    end
    checks++; if (dropped !== 4'b0000) begin failures++; $display("[TB] FAIL enfall_dropped: got %b expected 0000", dropped); end
  endtask

  task automatic test_timeout();
    resetDut();
    rx_data_uart[0] = 64'h70;
    rx_data_uart[1] = 64'h71;
    applyStimulus(4'b1100, 4'b1111, 1'b1);
    runCycles(60);
`ifdef RX_TIMEOUT_EN
    checks++; if (timeoutCycle.size() < 1) begin
      failures++; $display("[TB] FAIL timeout_seen: got 0 pulses expected >=1");
    end else begin
      checks++; if (timeoutCycle[0] !== 50) begin failures++; $display("[TB] FAIL timeout_cycle: got %0d expected 50", timeoutCycle[0]); end
    end
    checks++; if (flagCycle.size() < 2) begin
      failures++; $display("[TB] FAIL timeout_next_issue: got %0d flags expected 2", flagCycle.size());
    end else begin
      checks++; if (flagCycle[1] !== 52 || flagGrant[1] !== 4'b0010 || flagData[1] !== 64'h71) begin
        failures++; $display("[TB] FAIL timeout_next_data: got %0d/%b/%0h expected 52/0010/71", flagCycle[1], flagGrant[1], flagData[1]);
      end
    end
`else
    checks++; if (flagCycle.size() !== 1) begin failures++; $display("[TB] FAIL wait_hold: got %0d flags expected 1", flagCycle.size()); end
    checks++; if (timeoutCycle.size() !== 0) begin failures++; $display("[TB] FAIL wait_no_timeout: got %0d expected 0", timeoutCycle.size()); end
    comms_busy = 1'b0;
    runCycles(6);
    checks++; if (flagCycle.size() !== 2) begin
      failures++; $display("[TB] FAIL wait_release_count: got %0d expected 2", flagCycle.size());
    end else begin
      checks++; if (flagCycle[1] !== 62 || flagGrant[1] !== 4'b0010 || flagData[1] !== 64'h71) begin
        failures++; $display("[TB] FAIL wait_release_data: got %0d/%b/%0h expected 62/0010/71", flagCycle[1], flagGrant[1], flagData[1]);
      end
    end
`endif
  endtask

  task automatic test_reset_midop();
    resetDut();
    rx_data_uart[0] = 64'h10;
    rx_data_uart[1] = 64'h11;
    rx_data_uart[2] = 64'h12;
    applyStimulus(4'b1000, 4'b1111, 1'b1);
    runCycles(8);
    checks++; if (dut.state_q !== WAIT_COMMS || dut.hold_valid_q !== 4'b0110) begin
      failures++; $display("[TB] FAIL midop_setup: got state %0d hold %b expected 3 0110", dut.state_q, dut.hold_valid_q);
    end
    reset = 1'b1;
    #1;
    checks++; if (rx_data !== '0 || grant !== '0 || rx_data_flag !== 1'b0 || dropped !== '0 || timeout_flag !== 1'b0) begin
      failures++; $display("[TB] FAIL midop_outputs: got %0h %b %0b %b %0b expected all zero", rx_data, grant, rx_data_flag, dropped, timeout_flag);
    end
    checks++; if (dut.state_q !== IDLE || dut.hold_valid_q !== 4'b0000) begin
      failures++; $display("[TB] FAIL midop_state: got %0d hold %b expected IDLE 0000", dut.state_q, dut.hold_valid_q);
    end
    rx_data_uart[3] = 64'h33;
    rx_empty_uart = 4'b0111;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      checks++; if (uld_rx_data_uart !== 4'b0000) begin failures++; $display("[TB] FAIL midop_uld_in_reset: got %b expected 0000", uld_rx_data_uart); end
    end
    rx_empty_uart = 4'b1111;
    comms_busy = 1'b0;
    reset = 1'b0;
    clearLog();
    runCycles(10);
    checks++; if (flagCycle.size() !== 0) begin failures++; $display("[TB] FAIL midop_no_flag: got %0d expected 0", flagCycle.size()); end
    rx_empty_uart = 4'b0111;
    runCycles(8);
    checks++; if (flagCycle.size() !== 1) begin
      failures++; $display("[TB] FAIL midop_new_count: got %0d expected 1", flagCycle.size());
    end else begin
      checks++; if (flagGrant[0] !== 4'b1000 || flagData[0] !== 64'h33) begin failures++; $display("[TB] FAIL midop_new_data: got %b/%0h expected 1000/33", flagGrant[0], flagData[0]); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_all_ports();
    test_round_robin();
    test_drop();
    test_same_cycle();
    test_enable_fall();
    test_timeout();
    test_reset_midop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no finish expected finish within 200000 time units");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
